// File: rtl/cache_controller_if.sv
// rtl/cache_controller_if.sv - CPU/cache-array/memory signals seen by the cache controller
//
// Ports (via modports):
//   master: drives MemRead, MemWrite, Word_Address, valid, mem_ready;
//           observes hit_miss, CacheRead, CacheWrite, MainMemRead,
//           MainMemWrite, stall, hit_count, miss_count
//   slave : the controller side, directions mirrored
interface cache_controller_if #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
);
    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] Word_Address;
    logic              valid;
    logic              mem_ready;
    logic              hit_miss;
    logic              CacheRead;
    logic              CacheWrite;
    logic              MainMemRead;
    logic              MainMemWrite;
    logic              stall;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    modport master (
        output MemRead, MemWrite, Word_Address, valid, mem_ready,
        input  hit_miss, CacheRead, CacheWrite, MainMemRead, MainMemWrite,
               stall, hit_count, miss_count
    );

    modport slave (
        input  MemRead, MemWrite, Word_Address, valid, mem_ready,
        output hit_miss, CacheRead, CacheWrite, MainMemRead, MainMemWrite,
               stall, hit_count, miss_count
    );
endinterface

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - direct-mapped cache control: tag store, hit/miss, memory handshake, stats
//
// Ports:
//   clk   : clock, all state on rising edge
//   reset : synchronous active-low reset
//   bus   : cache_controller_if.slave (CPU request, array valid, memory
//           handshake in; cache/memory strobes, stall, counters out)
// Write-through, write-no-allocate, read-allocate.
module cache_controller #(
    parameter int ADDR_W  = 10,
    parameter int INDEX_W = 5,
    parameter int TAG_W   = 3,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    cache_controller_if.slave   bus
);
    localparam int LINES = 2 ** INDEX_W;

    typedef enum logic [1:0] {IDLE, READ_MISS, WRITE_MEM} state_t;

    state_t             state;
    logic [TAG_W-1:0]   tag_store [LINES];
    logic [CNT_W-1:0]   hit_cnt;
    logic [CNT_W-1:0]   miss_cnt;

    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   addr_tag;
    logic               hit;

    // Two low address bits select the word within a 4-word line.
    assign index    = bus.Word_Address[INDEX_W+1:2];
    assign addr_tag = bus.Word_Address[ADDR_W-1:INDEX_W+2];
    assign hit      = bus.valid && (tag_store[index] == addr_tag);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            hit_cnt  <= '0;
            miss_cnt <= '0;
            for (int i = 0; i < LINES; i++) begin
                tag_store[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    // Read wins when both requests are raised together.
                    if (bus.MemRead) begin
                        if (hit) begin
                            if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
                        end else begin
                            if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
                            state <= READ_MISS;
                        end
                    end else if (bus.MemWrite) begin
                        if (hit) begin
                            if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
                        end else begin
                            if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
                        end
                        state <= WRITE_MEM;
                    end
                end
                READ_MISS: begin
                    // The array fills the line on this same edge; the retried
                    // read then hits in IDLE and is counted there.
                    if (bus.mem_ready) begin
                        tag_store[index] <= addr_tag;
                        state            <= IDLE;
                    end
                end
                WRITE_MEM: begin
                    if (bus.mem_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.hit_miss     = hit;
        bus.CacheRead    = 1'b0;
        bus.CacheWrite   = 1'b0;
        bus.MainMemRead  = 1'b0;
        bus.MainMemWrite = 1'b0;
        bus.stall        = 1'b0;
        case (state)
            IDLE: begin
                if (bus.MemRead) begin
                    bus.CacheRead   = 1'b1;
                    bus.MainMemRead = !hit;
                    bus.stall       = !hit;
                end else if (bus.MemWrite) begin
                    bus.CacheWrite   = 1'b1;
                    bus.MainMemWrite = 1'b1;
                    bus.stall        = 1'b1;
                end
            end
            READ_MISS: begin
                bus.CacheRead   = 1'b1;
                bus.MainMemRead = 1'b1;
                bus.stall       = 1'b1;
            end
            WRITE_MEM: begin
                bus.CacheWrite   = 1'b1;
                bus.MainMemWrite = 1'b1;
                // CPU advances in the completion cycle itself.
                bus.stall        = !bus.mem_ready;
            end
            default: ;
        endcase
    end

    assign bus.hit_count  = hit_cnt;
    assign bus.miss_count = miss_cnt;
endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - directed self-checking bench for cache_controller
module tb_cache_controller;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    cache_controller_if #(.ADDR_W(10), .CNT_W(16)) bus ();

    cache_controller #(
        .ADDR_W(10), .INDEX_W(5), .TAG_W(3), .CNT_W(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issues one CPU request and follows it to completion. mem_ready is
    // pulsed in cycle 'delay' counted from the request cycle (0 = never).
    task automatic run_op(input string tag, input bit is_wr, input logic [9:0] addr,
                          input logic v, input int delay, input int exp_stalls,
                          input logic exp_hit);
        int  k;
        int  stalls;
        bit  done;
        k = 0;
        stalls = 0;
        done = 1'b0;
        bus.Word_Address = addr;
        bus.valid        = v;
        bus.MemRead      = !is_wr;
        bus.MemWrite     = is_wr;
        bus.mem_ready    = 1'b0;
        while (!done && k < 32) begin
            @(negedge clk);
            if (k == 0) check({tag, "_hit"}, bus.hit_miss, exp_hit);
            if (bus.stall) begin
                stalls++;
                if (is_wr) check({tag, "_mmw"}, bus.MainMemWrite, 1);
                else       check({tag, "_mmr"}, bus.MainMemRead, 1);
            end else begin
                done = 1'b1;
                if (is_wr) begin
                    check({tag, "_mmw_end"}, bus.MainMemWrite, 1);
                    check({tag, "_cw_end"}, bus.CacheWrite, 1);
                end else begin
                    check({tag, "_cr_end"}, bus.CacheRead, 1);
                    check({tag, "_mmr_end"}, bus.MainMemRead, 0);
                    check({tag, "_hit_end"}, bus.hit_miss, 1);
                end
            end
            @(posedge clk);
            #1;
            if (bus.mem_ready && !is_wr) bus.valid = 1'b1;
            k++;
            bus.mem_ready = (k == delay) && !done;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_stalls"}, stalls, exp_stalls);
        bus.mem_ready = 1'b0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        bus.MemRead = 1'b0;
        bus.MemWrite = 1'b0;
        bus.Word_Address = '0;
        bus.valid = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_stall", bus.stall, 0);
        check("rst_cr", bus.CacheRead, 0);
        check("rst_mmr", bus.MainMemRead, 0);
        check("rst_hits", bus.hit_count, 0);
        check("rst_miss", bus.miss_count, 0);
        @(posedge clk); #1;

        // 0x085: tag 1, index 1, cold miss, fill after 1 cycle
        run_op("rd085", 1'b0, 10'h085, 1'b0, 1, 2, 1'b0);
        check("rd085_miss", bus.miss_count, 1);
        check("rd085_hits", bus.hit_count, 1);

        // 0x086: same line, hit with zero latency
        run_op("rd086", 1'b0, 10'h086, 1'b1, 0, 0, 1'b1);
        check("rd086_hits", bus.hit_count, 2);

        // 0x105: tag 2 conflicts with tag 1 at index 1, ready in 3rd miss cycle
        run_op("rd105", 1'b0, 10'h105, 1'b1, 3, 4, 1'b0);
        check("rd105_miss", bus.miss_count, 2);
        check("rd105_hits", bus.hit_count, 3);

        // Write hit on 0x105
        run_op("wr105", 1'b1, 10'h105, 1'b1, 2, 2, 1'b1);
        check("wr105_hits", bus.hit_count, 4);
        check("wr105_miss", bus.miss_count, 2);

        // Write miss on invalid line 31 (tag 7): no allocation
        run_op("wr3ff", 1'b1, 10'h3FF, 1'b0, 1, 1, 1'b0);
        check("wr3ff_miss", bus.miss_count, 3);
        check("wr3ff_hits", bus.hit_count, 4);

        // Tag 0 at index 31 still hits, so the write left tag[31] at 0
        run_op("rd07f", 1'b0, 10'h07F, 1'b1, 0, 0, 1'b1);
        check("rd07f_hits", bus.hit_count, 5);

        // Read and write together: read serviced, write ignored
        bus.Word_Address = 10'h105;
        bus.valid = 1'b1;
        bus.MemRead = 1'b1;
        bus.MemWrite = 1'b1;
        @(negedge clk);
        check("both_cr", bus.CacheRead, 1);
        check("both_cw", bus.CacheWrite, 0);
        check("both_mmw", bus.MainMemWrite, 0);
        check("both_stall", bus.stall, 0);
        @(posedge clk); #1;
        bus.MemRead = 1'b0;
        bus.MemWrite = 1'b0;
        @(negedge clk);
        check("both_idle_cw", bus.CacheWrite, 0);
        check("both_hits", bus.hit_count, 6);

        // Idle with no request: strobes low, mem_ready ignored
        @(posedge clk); #1;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        check("idle_rdy_stall", bus.stall, 0);
        check("idle_rdy_mmw", bus.MainMemWrite, 0);
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;

        // Reset during READ_MISS
        bus.Word_Address = 10'h200;
        bus.valid = 1'b0;
        bus.MemRead = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rm_stall", bus.stall, 1);
        check("rm_miss", bus.miss_count, 4);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        bus.MemRead = 1'b0;
        @(negedge clk);
        check("rm_rst_stall", bus.stall, 0);
        check("rm_rst_cr", bus.CacheRead, 0);
        check("rm_rst_mmr", bus.MainMemRead, 0);
        check("rm_rst_hits", bus.hit_count, 0);
        check("rm_rst_miss", bus.miss_count, 0);
        @(posedge clk); #1;
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check("rm_late_rdy_cr", bus.CacheRead, 0);
        check("rm_late_rdy_mmr", bus.MainMemRead, 0);
        check("rm_late_rdy_stall", bus.stall, 0);
        // tag[1] was 2 before reset; cleared store makes 0x105 miss
        bus.Word_Address = 10'h105;
        bus.valid = 1'b1;
        #1;
        check("rm_tag_cleared", bus.hit_miss, 0);
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
Control stage sitting directly upstream of the direct-mapped cache data array (32 lines × 4 words, 10-bit word address). Owns the 32-entry tag store and performs the hit/miss compare. Drives the array's CacheRead/CacheWrite/hit_miss strobes and the main-memory read/write handshake, and stalls the CPU. Policy is write-through, write-no-allocate, read-allocate; it keeps hit/miss statistics.

Parameters:
ADDR_W, 10, word address width
INDEX_W, 5, line index width (Word_Address[6:2])
TAG_W, 3, tag width (Word_Address[9:7])
CNT_W, 16, width of the statistics counters

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous active-low reset
MemRead  input  1  CPU load request, held until stall=0
MemWrite  input  1  CPU store request, held until stall=0
Word_Address  input  10  CPU word address, stable while stall=1
valid  input  1  valid bit of the indexed line, from the cache array
mem_ready  input  1  main memory completion pulse, one cycle
hit_miss  output  1  1 = hit, to the cache array
CacheRead  output  1  cache read/fill strobe
CacheWrite  output  1  cache write strobe
MainMemRead  output  1  block fetch request to memory
MainMemWrite  output  1  word write-through request to memory
stall  output  1  CPU hold
hit_count  output  16  saturating count of completed hits
miss_count  output  16  saturating count of misses

Behaviour:
- Reset: one clk with reset=0 puts the FSM in IDLE, clears all tag entries to 0 and clears both counters. Combinationally this drives all strobes and stall to 0. The valid bits live in the cache array and are cleared by that array's reset.
- Reset mid-operation: an in-flight miss or write is abandoned. A later mem_ready for the abandoned request is ignored in IDLE.
- hit = valid && (tag_store[Word_Address[6:2]] == Word_Address[9:7]). hit_miss = hit in every state. It is combinational.
- States: IDLE, READ_MISS, WRITE_MEM.
- IDLE, read hit (MemRead=1): CacheRead=1 and stall=0 in the same cycle, so latency is 0. hit_count increments.
- IDLE, read miss: CacheRead=1, MainMemRead=1, stall=1. Next state READ_MISS. miss_count increments once, on entry.
- READ_MISS: CacheRead=1, MainMemRead=1, stall=1 every cycle.
  - On mem_ready=1, the cache array fills the line that edge, tag_store[index] <= addr tag, and next state is IDLE.
  - Next cycle in IDLE the request hits, delivers data and counts a hit. Minimum miss latency is 2 cycles when mem_ready arrives in the first READ_MISS cycle.
- IDLE, MemWrite=1: CacheWrite=1, MainMemWrite=1, stall=1. Next state WRITE_MEM. Hit or miss is counted on entry.
- WRITE_MEM: CacheWrite=1 and MainMemWrite=1. stall = !mem_ready. On mem_ready, next state is IDLE and the CPU advances in that same cycle.
  - On a hit the array updates the word every CacheWrite cycle. Rewriting the same data is harmless.
  - On a miss the array does not allocate, and the tag store is not written.
- MemRead and MemWrite both 1 in IDLE: the read is serviced and the write is ignored.
- Neither request asserted in IDLE: all outputs are 0.
- mem_ready is ignored in IDLE.
- Counters saturate at 2^CNT_W−1 and never wrap.
- The tag store is written only on a READ_MISS completion.

Test Plan:
- Read 0x085 after reset (valid=0):
  - Required: miss. stall=1, MainMemRead=1 until mem_ready.
  - Required after fill: tag[1]=1. Next cycle hit_miss=1, stall=0. miss_count=1, hit_count=1.
- Read 0x086 after the previous fill, valid=1:
  - Required: hit in the same cycle. stall=0, CacheRead=1, no MainMemRead. hit_count=2.
- Read 0x105 (tag 2, index 1), conflict with tag 1:
  - Required: miss. With mem_ready after 3 cycles, stall is high for 4 cycles. tag[1]=2, miss_count=2.
- Write 0x105 with valid=1:
  - Required: hit_miss=1, CacheWrite=1, MainMemWrite=1. stall drops in the mem_ready cycle. hit_count increments.
- Write 0x3FF on an invalid line:
  - Required: hit_miss=0, MainMemWrite until ready. tag[31] stays 0. miss_count increments.
- reset=0 during READ_MISS:
  - Required: next cycle IDLE, all outputs 0, counters 0. A later mem_ready pulse has no effect.
